// File: rtl/riscv_pkg.sv
// riscv_pkg: shared forwarding/MDU encodings for the pipeline hazard controller.
package riscv_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_t;
    // M beats W so the youngest in-flight value wins on a double match
    function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic rw_m,
                                         input logic rw_w);
        return (rw_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
               (rw_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/mdu_seq.sv
// mdu_seq: IDLE/BUSY/DONE sequencer timing how long a MUL/DIV op occupies E.
module mdu_seq
    import riscv_pkg::*;
#(
    parameter int MUL_CYC = 4,
    parameter int DIV_CYC = 34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mdu_op_E,
    input  logic       mdu_div_E,
    output mdu_state_t state,
    output logic       mdu_busy,
    output logic       mdu_done
);
    localparam int CW = $clog2(DIV_CYC);
    // IDLE and DONE each take one cycle, BUSY takes cnt+1
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYC - 3);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYC - 3);
    mdu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: if (mdu_op_E) begin
                state_d = MDU_BUSY;
                cnt_d   = mdu_div_E ? DIV_LD : MUL_LD;
            end
            MDU_BUSY: begin
                state_d = cnt_q == '0 ? MDU_DONE : MDU_BUSY;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = MDU_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign state    = state_q;
    assign mdu_busy = state_q != MDU_IDLE;
    assign mdu_done = state_q == MDU_DONE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush, MDU-occupancy stall/flush and E-stage forwarding control.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MUL_CYC = 4,
    parameter int DIV_CYC = 34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regwrite_M,
    input  logic       regwrite_W,
    input  logic       memread_E,
    input  logic       pcsrc_E,
    input  logic       mdu_op_E,
    input  logic       mdu_div_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_M,
    output logic [1:0] fwd_a_E,
    output logic [1:0] fwd_b_E,
    output logic       mdu_busy,
    output logic       mdu_done
);
    mdu_state_t st;
    logic       mdu_go, mdu_stall, lwstall;
    // a taken branch squashes whatever sits in E, so it never starts the MDU
    assign mdu_go = mdu_op_E & ~pcsrc_E;
    mdu_seq #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .mdu_op_E (mdu_go),
        .mdu_div_E(mdu_div_E),
        .state    (st),
        .mdu_busy (mdu_busy),
        .mdu_done (mdu_done)
    );
    assign mdu_stall = mdu_go && st != MDU_DONE;
    assign lwstall   = memread_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
    assign fwd_a_E   = fwd_sel(rs1_E, rd_M, rd_W, regwrite_M, regwrite_W);
    assign fwd_b_E   = fwd_sel(rs2_E, rd_M, rd_W, regwrite_M, regwrite_W);
    assign stall_F   = lwstall | mdu_stall;
    assign stall_D   = lwstall | mdu_stall;
    assign stall_E   = mdu_stall;
    assign flush_M   = mdu_stall;
    assign flush_D   = pcsrc_E;
    assign flush_E   = pcsrc_E | (lwstall & ~mdu_stall);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl; expected output vectors queued per cycle.
module tb_hazard_ctrl;
    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 34;
    logic clk = 0, reset = 1;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic regwrite_M, regwrite_W, memread_E, pcsrc_E, mdu_op_E, mdu_div_E;
    logic stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mdu_busy, mdu_done;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic [11:0] obs, e;
    logic [11:0] sb[$];
    int checks = 0, failures = 0;

    hazard_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memread_E(memread_E), .pcsrc_E(pcsrc_E), .mdu_op_E(mdu_op_E), .mdu_div_E(mdu_div_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .flush_D(flush_D),
        .flush_E(flush_E), .flush_M(flush_M), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    always #5 clk = ~clk;
    assign obs = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, fwd_a_E, fwd_b_E, mdu_busy, mdu_done};

    function automatic logic [11:0] mk(input logic sf, sd, se, fd, fe, fm,
                                       input logic [1:0] fa, fb, input logic bz, dn);
        return {sf, sd, se, fd, fe, fm, fa, fb, bz, dn};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, rdm, rdw, input logic wm, ww);
        if (wm && rdm != 0 && rdm == rs) return 2'b10;
        if (ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {regwrite_M, regwrite_W, memread_E, pcsrc_E, mdu_op_E, mdu_div_E} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        sb.push_back('0);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset: got %b expected %b", obs, e);
        end
        reset = 0;
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [4:0] tbl [6][6] = '{
            '{5, 5, 5, 5, 5, 0}, '{0, 5, 5, 9, 5, 5}, '{3, 4, 7, 4, 4, 3},
            '{6, 6, 6, 6, 6, 6}, '{0, 0, 0, 0, 0, 0}, '{8, 9, 8, 9, 1, 2}};
        logic [1:0] wr [6] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01};
        for (int i = 0; i < 6; i++) begin
            rd_M = tbl[i][0]; rd_W = tbl[i][1]; rs1_E = tbl[i][2]; rs2_E = tbl[i][3];
            rs1_D = tbl[i][4]; rs2_D = tbl[i][5];
            {regwrite_M, regwrite_W} = wr[i];
            sb.push_back(mk(0, 0, 0, 0, 0, 0, ref_fwd(rs1_E, rd_M, rd_W, regwrite_M, regwrite_W),
                            ref_fwd(rs2_E, rd_M, rd_W, regwrite_M, regwrite_W), 0, 0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL fwd[%0d]: got %b expected %b", i, obs, e);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        // {memread, rd_E, rs1_D, rs2_D, expect_stall}
        logic [4:0] tbl [5][5] = '{
            '{1, 7, 0, 7, 1}, '{1, 0, 0, 0, 0}, '{1, 9, 9, 2, 1}, '{0, 7, 7, 7, 0}, '{1, 4, 5, 6, 0}};
        for (int i = 0; i < 5; i++) begin
            memread_E = tbl[i][0][0]; rd_E = tbl[i][1]; rs1_D = tbl[i][2]; rs2_D = tbl[i][3];
            sb.push_back(mk(tbl[i][4][0], tbl[i][4][0], 0, 0, tbl[i][4][0], 0, 0, 0, 0, 0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            pcsrc_E = (i == 0);
            sb.push_back(mk(0, 0, 0, pcsrc_E, pcsrc_E, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, e);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back(input logic div, input int n_ops);
        int cyc = div ? DIV_CYC : MUL_CYC;
        int p;
        logic s;
        mdu_op_E = 1; mdu_div_E = div;
        for (int k = 1; k <= n_ops * cyc; k++) begin
            p = (k - 1) % cyc + 1;
            s = p < cyc;
            sb.push_back(mk(s, s, s, 0, 0, s, 0, 0, p > 1, p == cyc));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mdu div=%0d cyc%0d: got %b expected %b", div, k, obs, e);
            end
            next_cycle();
        end
        clear_inputs();
        sb.push_back('0);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mdu_idle_after div=%0d: got %b expected %b", div, obs, e);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        mdu_op_E = 1; mdu_div_E = 1; memread_E = 1; rd_E = 3; rs1_D = 3;
        for (int k = 1; k <= 23; k++) begin
            sb.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, k > 1, 0));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mid_op cyc%0d: got %b expected %b", k, obs, e);
            end
            if (k == 23) reset = 1;
            next_cycle();
        end
        reset = 0;
        clear_inputs();
        sb.push_back('0);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mid_op_reset: got %b expected %b", obs, e);
        end
        next_cycle();
        memread_E = 1; rd_E = 3; rs2_D = 3;
        sb.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL lw_after_reset: got %b expected %b", obs, e);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_lw_during_mdu();
        mdu_op_E = 1; memread_E = 1; rd_E = 12; rs2_D = 12;
        for (int k = 1; k <= MUL_CYC; k++) begin
            sb.push_back(k < MUL_CYC ? mk(1, 1, 1, 0, 0, 1, 0, 0, k > 1, 0)
                                     : mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL lw_in_mdu cyc%0d: got %b expected %b", k, obs, e);
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back(0, 1);
        test_back_to_back(0, 2);
        test_back_to_back(1, 1);
        test_lw_during_mdu();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
